// File: rtl/pcpo_contabits.sv
// Multi-cycle bit counter: ones, zeros, trailing zeros or leading zeros of a
// WIDTH-bit operand, one bit per clock, with a start/pronto handshake and
// early termination once the remaining operand cannot change the result.
module pcpo_contabits #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       modo,
  output logic [RW-1:0]    resultado,
  output logic             pronto,
  output logic             ocupado
);

  typedef enum logic [1:0] {
    StOcioso,
    StConta,
    StFim
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  // High for the zero-run modes (10/11), which stop at the first set bit.
  logic             run_mode_q, run_mode_d;
  logic [WIDTH-1:0] a_rev;

  // Bit-reversed operand so leading zeros reuse the trailing-zero walk.
  always_comb begin
    a_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_rev[i] = A[WIDTH-1-i];
    end
  end

  // Next-state logic: load on accepted start, walk R one bit per cycle.
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    run_mode_d = run_mode_q;
    unique case (state_q)
      StOcioso, StFim: begin
        if (start) begin
          run_mode_d = modo[1];
          cnt_d      = '0;
          state_d    = StConta;
          unique case (modo)
            2'b00:   r_d = A;
            2'b01:   r_d = ~A;
            2'b10:   r_d = A;
            default: r_d = a_rev;
          endcase
        end
      end
      StConta: begin
        if (!run_mode_q) begin
          if (r_q == '0) begin
            state_d = StFim;
          end else begin
            if (r_q[0]) begin
              cnt_d = cnt_q + RW'(1);
            end
            r_d = r_q >> 1;
          end
        end else begin
          if (r_q == '0) begin
            // No set bit at all: the whole operand is the zero run.
            cnt_d   = RW'(WIDTH);
            state_d = StFim;
          end else if (r_q[0]) begin
            state_d = StFim;
          end else begin
            cnt_d = cnt_q + RW'(1);
            r_d   = r_q >> 1;
          end
        end
      end
      default: state_d = StOcioso;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StOcioso;
      r_q        <= '0;
      cnt_q      <= '0;
      run_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      run_mode_q <= run_mode_d;
    end
  end

  assign pronto    = (state_q == StFim);
  assign ocupado   = (state_q == StConta);
  // Result is only exposed in FIM so it never shows partial counts.
  assign resultado = pronto ? cnt_q : '0;

endmodule

// File: tb/tb_pcpo_contabits.sv
// Bench for pcpo_contabits: a WIDTH=16 and a WIDTH=8 instance checked every
// cycle against an operation-level model, plus literal result/latency checks.
module tb_pcpo_contabits;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        st [2];
  logic [15:0] av [2];
  logic [1:0]  mv [2];
  logic        po0, po1, oc0, oc1;
  logic [4:0]  res16;
  logic [3:0]  res8;

  int vectors = 0;
  int miscompares = 0;

  // Model: 0 idle, 1 counting, 2 done.
  int mst [2];
  int mleft [2];
  int mres [2];

  always #5 clk = ~clk;

  pcpo_contabits #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(st[0]), .A(av[0]), .modo(mv[0]),
    .resultado(res16), .pronto(po0), .ocupado(oc0)
  );

  pcpo_contabits #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(st[1]), .A(av[1][7:0]), .modo(mv[1]),
    .resultado(res8), .pronto(po1), .ocupado(oc1)
  );

  function automatic int wd(int d);
    return (d == 0) ? 16 : 8;
  endfunction

  function automatic int ones(int w, logic [15:0] a);
    int c = 0;
    for (int i = 0; i < w; i++) if (a[i]) c++;
    return c;
  endfunction

  function automatic int hib(int w, logic [15:0] a);
    for (int i = w - 1; i >= 0; i--) if (a[i]) return i + 1;
    return 0;
  endfunction

  function automatic int tzc(int w, logic [15:0] a);
    for (int i = 0; i < w; i++) if (a[i]) return i;
    return w;
  endfunction

  function automatic int lzc(int w, logic [15:0] a);
    for (int i = w - 1; i >= 0; i--) if (a[i]) return w - 1 - i;
    return w;
  endfunction

  function automatic int calc_res(int w, logic [15:0] a, logic [1:0] m);
    case (m)
      2'b00:   return ones(w, a);
      2'b01:   return w - ones(w, a);
      2'b10:   return tzc(w, a);
      default: return lzc(w, a);
    endcase
  endfunction

  // Edges from the accepting edge to the edge entering FIM.
  function automatic int calc_lat(int w, logic [15:0] a, logic [1:0] m);
    int z;
    case (m)
      2'b00:   return hib(w, a) + 1;
      2'b01:   return hib(w, ~a) + 1;
      2'b10:   begin z = tzc(w, a); return (z == w) ? 1 : z + 1; end
      default: begin z = lzc(w, a); return (z == w) ? 1 : z + 1; end
    endcase
  endfunction

  function automatic logic pout(int d);
    return (d == 0) ? po0 : po1;
  endfunction

  function automatic logic oout(int d);
    return (d == 0) ? oc0 : oc1;
  endfunction

  function automatic int rout(int d);
    return (d == 0) ? int'(res16) : int'(res8);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Operation-level model advanced on each rising edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mst[d] <= 0;
        mleft[d] <= 0;
        mres[d] <= 0;
      end else if (mst[d] != 1 && st[d]) begin
        mst[d] <= 1;
        mleft[d] <= calc_lat(wd(d), av[d], mv[d]);
        mres[d] <= calc_res(wd(d), av[d], mv[d]);
      end else if (mst[d] == 1) begin
        mleft[d] <= mleft[d] - 1;
        if (mleft[d] == 1) mst[d] <= 2;
      end
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ocupado[%0d]", d), int'(oout(d)), (mst[d] == 1) ? 1 : 0);
      chk($sformatf("pronto[%0d]", d), int'(pout(d)), (mst[d] == 2) ? 1 : 0);
      if (mst[d] != 1)
        chk($sformatf("resultado[%0d]", d), rout(d), (mst[d] == 2) ? mres[d] : 0);
    end
  end

  // One operation; A/modo are scrambled after the accepting edge.
  task automatic run_op(input int d, input logic [15:0] a, input logic [1:0] m,
                        input bit lit, input int er, input int el);
    int n;
    @(negedge clk);
    st[d] = 1'b1;
    av[d] = a;
    mv[d] = m;
    @(negedge clk);
    st[d] = 1'b0;
    av[d] = 16'($urandom);
    mv[d] = 2'($urandom);
    n = 0;
    while (!pout(d) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("timeout", n, 0);
    if (lit) begin
      chk($sformatf("lat d%0d a%h m%0d", d, a, m), n, el);
      chk($sformatf("res d%0d a%h m%0d", d, a, m), rout(d), er);
    end
  endtask

  typedef struct {
    int d; logic [15:0] a; logic [1:0] m; int er; int el;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int n, pulses;
    logic prev;
    tbl[0] = '{0, 16'hF0F0, 2'b00, 8, 17};
    tbl[1] = '{0, 16'h0000, 2'b00, 0, 1};
    tbl[2] = '{0, 16'h0000, 2'b01, 16, 17};
    tbl[3] = '{0, 16'hFFFF, 2'b01, 0, 1};
    tbl[4] = '{0, 16'h0008, 2'b10, 3, 4};
    tbl[5] = '{0, 16'h0000, 2'b10, 16, 1};
    tbl[6] = '{0, 16'h0008, 2'b11, 12, 13};
    tbl[7] = '{0, 16'h8000, 2'b11, 0, 1};
    tbl[8] = '{1, 16'h00FF, 2'b00, 8, 9};
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; av[d] = '0; mv[d] = '0;
      mst[d] = 0; mleft[d] = 0; mres[d] = 0;
    end

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset pronto", int'(po0), 0);
    chk("reset ocupado", int'(oc0), 0);
    chk("reset resultado", int'(res16), 0);
    reset = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].d, tbl[i].a, tbl[i].m, 1'b1, tbl[i].er, tbl[i].el);

    // Start pulsed again mid-operation must be ignored.
    @(negedge clk);
    st[0] = 1'b1; av[0] = 16'hFFFF; mv[0] = 2'b00;
    @(negedge clk);
    st[0] = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); n++; end
    st[0] = 1'b1; av[0] = 16'h0001;
    @(negedge clk);
    n++;
    st[0] = 1'b0;
    while (!po0 && n < 60) begin @(negedge clk); n++; end
    chk("ignored start lat", n, 17);
    chk("ignored start res", int'(res16), 16);

    // Reset mid-operation aborts, then a fresh start works.
    @(negedge clk);
    st[0] = 1'b1; av[0] = 16'hF0F0; mv[0] = 2'b00;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort pronto", int'(po0), 0);
    chk("abort ocupado", int'(oc0), 0);
    chk("abort resultado", int'(res16), 0);
    reset = 1'b0;
    run_op(0, 16'h0008, 2'b10, 1'b1, 3, 4);

    // Start held high on the 8-bit instance: one-cycle pronto per operation.
    @(negedge clk);
    st[1] = 1'b1; av[1] = 16'h00FF; mv[1] = 2'b00;
    @(negedge clk);
    pulses = 0;
    prev = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (po1) pulses++;
      if (po1 && prev) chk("pronto width", 2, 1);
      prev = po1;
    end
    chk("back-to-back pulses", pulses, 5);
    st[1] = 1'b0;
    repeat (20) @(negedge clk);

    // Randomized operations, biased towards sparse operands.
    for (int i = 0; i < 150; i++) begin
      int d;
      logic [15:0] a;
      d = int'($urandom_range(0, 1));
      a = 16'($urandom);
      if ($urandom_range(0, 2) == 0) a = a & (16'h1 << $urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(d, a, 2'($urandom), 1'b0, 0, 0);
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pcpo_contabits.md
# pcpo_contabits

Parametrised successor to the 16-bit ones-counter control/datapath pair. It counts bits of a WIDTH-bit operand in one of four modes, one bit per clock: ones, zeros, trailing zeros or leading zeros. A start/pronto handshake frames each operation, and the FSM terminates early once the remaining operand can no longer change the result. It sits beside the existing counter in the datapath and serves any block needing a multi-cycle bit count without a wide combinational adder tree.

## Interface
- WIDTH, 16, operand width in bits; legal range is WIDTH >= 2.
- RW, $clog2(WIDTH+1), result width (derived; must hold WIDTH).
- clk  input  1  single clock; everything is updated on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled when not busy.
- A  input  WIDTH  operand; sampled only on the accepted start edge.
- modo  input  2  mode, sampled with A:
  - 00 = count ones.
  - 01 = count zeros.
  - 10 = count trailing zeros (LSB upward).
  - 11 = count leading zeros (MSB downward).
- resultado  output  RW  count; valid and stable while pronto=1.
- pronto  output  1  operation complete; held high until the next accepted start.
- ocupado  output  1  high while counting (state CONTA).

## Operation
- State OCIOSO (entered only by reset): ocupado=0, pronto=0, resultado=0.
- On start=1 in OCIOSO or FIM:
  - Load working register R per mode:
    - modo=00: R=A.
    - modo=01: R=~A.
    - modo=10: R=A.
    - modo=11: R=bit-reversed A.
  - Clear the counter, latch modo, set pronto=0, and go to CONTA.
- CONTA, modes 00/01, each cycle:
  - If R==0, go to FIM with the count unchanged.
  - Otherwise increment the count when R[0]=1, and shift R right one bit (zero fill).
- CONTA, modes 10/11, each cycle:
  - If R==0, load count=WIDTH and go to FIM.
  - Else if R[0]=1, go to FIM with the count unchanged.
  - Else increment the count and shift R right.
- FIM: pronto=1, ocupado=0, resultado holds the final count. The state is held until start is seen.
- start during CONTA is ignored; the operation is not restarted. A and modo changes during CONTA have no effect.
- The count never exceeds WIDTH, so no overflow handling is required.
- reset has priority over all other inputs in every state. Mid-operation it aborts to OCIOSO with all outputs 0 on the next edge.

## Timing
- Let t0 be the edge on which start is accepted. ocupado=1 from t0 until the edge entering FIM.
- Modes 00/01:
  - Let p = (index of the highest set bit of R as loaded) + 1, with p=0 if R==0.
  - CONTA lasts p+1 cycles and FIM is entered at edge t0+p+1.
- Modes 10/11:
  - Let z = trailing zeros of R as loaded.
  - If R≠0, FIM is entered at t0+z+1; if R==0, FIM is entered at t0+1.
- Worst-case latency is WIDTH+1 cycles; minimum is 1 cycle.
- pronto and resultado change only on the edge entering FIM or leaving it (accepted start).
- start held high continuously: a new operation starts on the edge after each FIM is reached, so pronto is high for exactly one cycle per operation.
- Reset values: pronto=0, ocupado=0, resultado=0, state OCIOSO.

## Test plan
- WIDTH=16, modo=00, A=16'hF0F0 -> resultado=8, pronto rises at t0+17. A=16'h0000 -> resultado=0 at t0+1.
- modo=01: A=16'h0000 -> 16 at t0+17. A=16'hFFFF -> 0 at t0+1.
- modo=10: A=16'h0008 -> 3 at t0+4. A=16'h0000 -> 16 at t0+1.
- modo=11: A=16'h0008 -> 12 at t0+13. A=16'h8000 -> 0 at t0+1.
- Pulse start again at t0+5 during a modo=00, A=16'hFFFF run -> ignored; resultado=16 at t0+17. Assert reset at t0+5 -> next edge has pronto=0, ocupado=0, resultado=0, and a fresh start then works.
- WIDTH=8 instance: modo=00, A=8'hFF -> resultado=8 at t0+9. Back-to-back starts held high yield a one-cycle pronto per operation.
